mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: PC, shared instruction/data memory port, instruction register, register file and ALU.
- Issues per-state mux selects and write enables. Stalls on a memory ready handshake. Reports instruction retirement for the benches.
- Sits between the instruction-register opcode field and the datapath; it replaces the hard-wired single-cycle decode.

Parameters:
- COUNT_W, 32, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 1. If 1, an unsupported opcode enters HALT. If 0, it retires as a NOP and returns to FETCH.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  instruction register load.
- mem_write  out  1  data memory write strobe.
- reg_write  out  1  register file write.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = memory data.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct field.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable: pc_write | (branch & zero).
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_count  out  COUNT_W  number of retired instructions; wraps modulo 2^COUNT_W.
- halted  out  1  high while in HALT.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
- Codes 13-15 are unreachable; if entered, the FSM goes to FETCH on the next clock.
- Reset, asynchronous: state=FETCH, instr_count=0, halted=0.
- While reset is high, ir_write, pc_en, mem_write and reg_write are forced to 0. All other outputs show their FETCH values.
- Outputs depend only on state, except the mem_ready and zero terms given below. Any output not listed for a state is 0.
  - FETCH: alu_src_b=01; ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0, otherwise go to DECODE.
  - DECODE: alu_src_b=11. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> HALT if HALT_ON_ILLEGAL=1, else FETCH with instr_done=1.
  - MEMADR: alu_src_a=1, alu_src_b=10. Go to MEMRD for lw, MEMWR for sw. Opcode is re-sampled here; the IR is stable.
  - MEMRD: iord=1. Hold while mem_ready=0, then go to MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Next state FETCH.
  - MEMWR: iord=1, mem_write=1. Hold while mem_ready=0; mem_write stays high throughout. When mem_ready=1: instr_done=1, next state FETCH.
  - EXECUTE: alu_src_a=1, alu_op=10. Next state ALUWB.
  - ALUWB: reg_dst=1, reg_write=1, instr_done=1. Next state FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1 (so pc_en=zero), instr_done=1. Next state FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10. Next state ADDIWB.
  - ADDIWB: reg_write=1, instr_done=1. Next state FETCH.
  - JUMP: pc_src=10, pc_write=1, instr_done=1. Next state FETCH.
  - HALT: halted=1, all enables 0. Only reset leaves HALT.
- instr_count increments on the clock edge at which instr_done=1. The value 2^COUNT_W-1 wraps to 0.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. A stall never drops an enable and never double-fires one.
- Reset asserted mid-instruction aborts the instruction immediately: no further write enables, and instr_count returns to 0.

Test Plan:
- Reset held, then released with mem_ready=1 and opcode=000000: state sequence 0,1,6,7,0. reg_dst=1 and reg_write=1 only in the ALUWB cycle. instr_count=1 after 4 cycles.
- opcode=100011 with mem_ready low for 2 cycles in MEMRD: state 3 lasts 3 cycles and iord=1 throughout. reg_write/mem_to_reg pulse exactly once in MEMWB. Total 7 cycles.
- opcode=000100: zero=1 gives pc_en=1 and pc_src=01 in BRANCH. zero=0 gives pc_en=0. Both retire in 3 cycles.
- opcode=101011 with mem_ready=0 for 1 cycle in MEMWR: mem_write high for 2 consecutive cycles. instr_done only on the second cycle.
- opcode=111111 with HALT_ON_ILLEGAL=1: state=12, halted=1, no enables, instr_count unchanged for 20 cycles. Reset returns state to 0.
- Preload instr_count=2^COUNT_W-1 via force, run one j: count wraps to 0. Assert reset during EXECUTE: no reg_write, state=0 asynchronously.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM. Sequences the shared-memory datapath one
// state per cycle, issues Moore-style mux selects and write enables, stalls
// on mem_ready and counts retired instructions.
//
// Handshake: the memory access issued in FETCH, MEMRD or MEMWR completes in
// the cycle mem_ready=1. The FSM holds its state and keeps every select and
// strobe stable while mem_ready=0. Enables qualified by mem_ready, such as
// ir_write and pc_en in FETCH, fire only in the completing cycle.
module mips_multicycle_control #(
  parameter int COUNT_W         = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic [COUNT_W-1:0] instr_count,
  output logic               halted
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] instr_count_q, instr_count_d;

  // Raw per-state enables before the reset gate.
  logic ir_write_c, mem_write_c, reg_write_c, pc_write_c, branch_c, done_c;

  // Per-state output decode and next-state selection.
  always_comb begin
    state_d     = state_q;
    iord        = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    pc_write_c  = 1'b0;
    branch_c    = 1'b0;
    done_c      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            // Unsupported opcode: either freeze or retire it as a NOP.
            if (HALT_ON_ILLEGAL) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
              done_c  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only lw/sw reach here; anything but sw is treated as a load.
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch_c  = 1'b1;
        done_c    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_c = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Retirement counter next value; wraps naturally at 2^COUNT_W.
  always_comb begin
    instr_count_d = instr_count_q;
    if (done_c) instr_count_d = instr_count_q + COUNT_W'(1);
  end

  // Write enables are gated by reset so an aborted instruction writes nothing.
  always_comb begin
    ir_write  = ir_write_c & ~reset;
    mem_write = mem_write_c & ~reset;
    reg_write = reg_write_c & ~reset;
    pc_en     = (pc_write_c | (branch_c & zero)) & ~reset;
  end

  assign instr_done  = done_c;
  assign state       = state_q;
  assign instr_count = instr_count_q;

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control. Inputs change and outputs are
// checked in the low phase of the clock, away from the rising edge.
module tb_mips_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        pc_en;
  logic [3:0]  state;
  logic        instr_done;
  logic [31:0] instr_count;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  mips_multicycle_control #(.COUNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .state      (state),
    .instr_done (instr_done),
    .instr_count(instr_count),
    .halted     (halted)
  );

  // Clock: 10 time units, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enables packed as {ir_write, pc_en, mem_write, reg_write, iord, instr_done}.
  logic [5:0] en_v;
  assign en_v = {ir_write, pc_en, mem_write, reg_write, iord, instr_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Let inputs settle, then check state and the enable vector.
  task automatic check_cycle(input string tag, input logic [3:0] st, input logic [5:0] en);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".en"}, 32'(en_v), 32'(en));
  endtask

  // One R-type instruction from FETCH with mem_ready high; 4 cycles.
  task automatic run_rtype(input string tag, input logic [31:0] cnt_after);
    opcode = 6'b000000;
    check_cycle({tag, ".f"}, 4'd0, 6'b110000);
    check({tag, ".f.srcb"}, 32'(alu_src_b), 32'd1);
    nxt();
    check_cycle({tag, ".d"}, 4'd1, 6'b000000);
    check({tag, ".d.srcb"}, 32'(alu_src_b), 32'd3);
    nxt();
    check_cycle({tag, ".e"}, 4'd6, 6'b000000);
    check({tag, ".e.aluop"}, 32'(alu_op), 32'd2);
    check({tag, ".e.srca"}, 32'(alu_src_a), 32'd1);
    check({tag, ".e.regdst"}, 32'(reg_dst), 32'd0);
    nxt();
    check_cycle({tag, ".wb"}, 4'd7, 6'b000101);
    check({tag, ".wb.regdst"}, 32'(reg_dst), 32'd1);
    nxt();
    check_cycle({tag, ".next"}, 4'd0, 6'b110000);
    check({tag, ".count"}, instr_count, cnt_after);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset held: FETCH values with write enables forced low.
    nxt();
    nxt();
    check_cycle("rst", 4'd0, 6'b000000);
    check("rst.srcb", 32'(alu_src_b), 32'd1);
    check("rst.count", instr_count, 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    reset = 1'b0;

    // R-type: 0,1,6,7,0; count 1.
    run_rtype("rt1", 32'd1);

    // lw with two stall cycles in MEMRD: 7 cycles.
    opcode = 6'b100011;
    check_cycle("lw.f", 4'd0, 6'b110000);
    nxt();
    check_cycle("lw.d", 4'd1, 6'b000000);
    nxt();
    check_cycle("lw.adr", 4'd2, 6'b000000);
    check("lw.adr.srcb", 32'(alu_src_b), 32'd2);
    check("lw.adr.srca", 32'(alu_src_a), 32'd1);
    nxt();
    mem_ready = 1'b0;
    check_cycle("lw.rd0", 4'd3, 6'b000010);
    nxt();
    check_cycle("lw.rd1", 4'd3, 6'b000010);
    nxt();
    mem_ready = 1'b1;
    check_cycle("lw.rd2", 4'd3, 6'b000010);
    nxt();
    check_cycle("lw.wb", 4'd4, 6'b000101);
    check("lw.wb.m2r", 32'(mem_to_reg), 32'd1);
    nxt();
    check_cycle("lw.next", 4'd0, 6'b110000);
    check("lw.count", instr_count, 32'd2);

    // beq taken and not taken: 3 cycles each.
    opcode = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      check_cycle("beq.f", 4'd0, 6'b110000);
      nxt();
      check_cycle("beq.d", 4'd1, 6'b000000);
      nxt();
      check_cycle("beq.br", 4'd8, (k == 0) ? 6'b010001 : 6'b000001);
      check("beq.pcsrc", 32'(pc_src), 32'd1);
      check("beq.aluop", 32'(alu_op), 32'd1);
      nxt();
      check("beq.count", instr_count, 32'(3 + k));
    end
    zero = 1'b0;

    // FETCH stall, then sw with one stall cycle in MEMWR.
    opcode    = 6'b101011;
    mem_ready = 1'b0;
    check_cycle("sw.fstall", 4'd0, 6'b000000);
    nxt();
    mem_ready = 1'b1;
    check_cycle("sw.f", 4'd0, 6'b110000);
    nxt();
    check_cycle("sw.d", 4'd1, 6'b000000);
    nxt();
    check_cycle("sw.adr", 4'd2, 6'b000000);
    nxt();
    mem_ready = 1'b0;
    check_cycle("sw.wr0", 4'd5, 6'b001010);
    nxt();
    mem_ready = 1'b1;
    check_cycle("sw.wr1", 4'd5, 6'b001011);
    nxt();
    check_cycle("sw.next", 4'd0, 6'b110000);
    check("sw.count", instr_count, 32'd5);

    // addi: 0,1,9,10.
    opcode = 6'b001000;
    nxt();
    check_cycle("addi.d", 4'd1, 6'b000000);
    nxt();
    check_cycle("addi.ex", 4'd9, 6'b000000);
    check("addi.ex.srcb", 32'(alu_src_b), 32'd2);
    nxt();
    check_cycle("addi.wb", 4'd10, 6'b000101);
    check("addi.wb.regdst", 32'(reg_dst), 32'd0);
    nxt();
    check("addi.count", instr_count, 32'd6);

    // j with counter preloaded to all ones: wraps to 0.
    opcode = 6'b000010;
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    check_cycle("j.f", 4'd0, 6'b110000);
    check("j.preload", instr_count, 32'hFFFF_FFFF);
    nxt();
    check_cycle("j.d", 4'd1, 6'b000000);
    nxt();
    check_cycle("j.jmp", 4'd11, 6'b010001);
    check("j.pcsrc", 32'(pc_src), 32'd2);
    nxt();
    check_cycle("j.next", 4'd0, 6'b110000);
    check("j.wrap", instr_count, 32'd0);

    // Illegal opcode: HALT for 20 cycles, then reset.
    opcode = 6'b111111;
    nxt();
    check_cycle("ill.d", 4'd1, 6'b000000);
    nxt();
    zero = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check_cycle("ill.halt", 4'd12, 6'b000000);
      check("ill.halted", 32'(halted), 32'd1);
      check("ill.count", instr_count, 32'd0);
      nxt();
    end
    zero  = 1'b0;
    reset = 1'b1;
    check_cycle("ill.rst", 4'd0, 6'b000000);
    check("ill.rst.halted", 32'(halted), 32'd0);
    nxt();
    reset = 1'b0;

    // Normal op after reset, then reset aborting an R-type in EXECUTE.
    run_rtype("rt2", 32'd1);
    opcode = 6'b000000;
    nxt();
    check_cycle("abort.d", 4'd1, 6'b000000);
    nxt();
    check_cycle("abort.e", 4'd6, 6'b000000);
    reset = 1'b1;
    check_cycle("abort.rst", 4'd0, 6'b000000);
    check("abort.count", instr_count, 32'd0);
    nxt();
    check_cycle("abort.held", 4'd0, 6'b000000);
    reset = 1'b0;
    run_rtype("rt3", 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
